// File: rtl/mdio_phy_target.sv
// PHY-side MDIO management target: decodes 32-bit Clause-22 frames sampled on MDC
// rising edges, serves a 32 x 16 register bank and drives read data on MDC falls.
module mdio_phy_target #(
    parameter logic [4:0]  PHY_ADDR = 5'd8,
    parameter logic [15:0] ID1      = 16'h0141,
    parameter logic [15:0] ID2      = 16'h0CB0
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic        WR_PULSE,
    output logic [4:0]  WR_ADDR,
    output logic [15:0] WR_DATA,
    output logic        FRAME_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST1,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_SKIP
    } state_t;

    state_t      r_state, w_state_next;
    logic [4:0]  r_bit_cnt, w_bit_cnt_next;
    logic        r_is_read, w_is_read_next;
    logic [4:0]  r_regad, w_regad_next;
    logic [15:0] r_sh, w_sh_next;
    logic [4:0]  r_out_cnt, w_out_cnt_next;
    logic        r_mdio_in, w_mdio_in_next;
    logic        r_mdio_in_oe, w_mdio_in_oe_next;
    logic        r_wr_pulse, w_wr_pulse_next;
    logic [4:0]  r_wr_addr, w_wr_addr_next;
    logic [15:0] r_wr_data, w_wr_data_next;
    logic        r_frame_err, w_frame_err_next;
    logic        r_mdc_q;
    logic        r_oe_q;

    logic        w_rise;
    logic        w_fall;
    logic        w_sample;
    logic        w_oe_fall;
    logic [15:0] w_shin;
    logic        w_ro;
    logic        w_bank_we;
    logic [15:0] w_rd_word;

    logic [15:0] r_bank [32];
    logic [15:0] w_bank_rst [32];

    assign w_rise    = MDC & ~r_mdc_q;
    assign w_fall    = ~MDC & r_mdc_q;
    assign w_sample  = w_rise & MDIO_OE;
    assign w_oe_fall = r_oe_q & ~MDIO_OE;
    assign w_shin    = {r_sh[14:0], MDIO_OUT};
    assign w_ro      = (r_regad == 5'd2) || (r_regad == 5'd3);
    assign w_rd_word = r_bank[r_regad];

    // Identification registers come out of reset holding the device ID.
    for (genvar gi = 0; gi < 32; gi++) begin : g_bank_rst
        assign w_bank_rst[gi] = (gi == 2) ? ID1 : ((gi == 3) ? ID2 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                r_bank[i] <= w_bank_rst[i];
            end
        end else if (w_bank_we) begin
            r_bank[r_regad] <= w_shin;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 5'd0;
            r_is_read    <= 1'b0;
            r_regad      <= 5'd0;
            r_sh         <= 16'h0000;
            r_out_cnt    <= 5'd0;
            r_mdio_in    <= 1'b0;
            r_mdio_in_oe <= 1'b0;
            r_wr_pulse   <= 1'b0;
            r_wr_addr    <= 5'd0;
            r_wr_data    <= 16'h0000;
            r_frame_err  <= 1'b0;
            r_mdc_q      <= 1'b0;
            r_oe_q       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_is_read    <= w_is_read_next;
            r_regad      <= w_regad_next;
            r_sh         <= w_sh_next;
            r_out_cnt    <= w_out_cnt_next;
            r_mdio_in    <= w_mdio_in_next;
            r_mdio_in_oe <= w_mdio_in_oe_next;
            r_wr_pulse   <= w_wr_pulse_next;
            r_wr_addr    <= w_wr_addr_next;
            r_wr_data    <= w_wr_data_next;
            r_frame_err  <= w_frame_err_next;
            r_mdc_q      <= MDC;
            r_oe_q       <= MDIO_OE;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = r_bit_cnt;
        w_is_read_next    = r_is_read;
        w_regad_next      = r_regad;
        w_sh_next         = r_sh;
        w_out_cnt_next    = r_out_cnt;
        w_mdio_in_next    = r_mdio_in;
        w_mdio_in_oe_next = r_mdio_in_oe;
        w_wr_pulse_next   = 1'b0;
        w_wr_addr_next    = r_wr_addr;
        w_wr_data_next    = r_wr_data;
        w_frame_err_next  = 1'b0;
        w_bank_we         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_sample && !MDIO_OUT) begin
                    w_state_next   = S_ST1;
                    w_bit_cnt_next = 5'd1;
                end
            end

            S_ST1: begin
                if (w_oe_fall) begin
                    w_state_next     = S_IDLE;
                    w_bit_cnt_next   = 5'd0;
                    w_frame_err_next = 1'b1;
                end else if (w_sample) begin
                    if (MDIO_OUT) begin
                        w_state_next   = S_OP;
                        w_bit_cnt_next = 5'd2;
                    end else begin
                        w_state_next     = S_IDLE;
                        w_bit_cnt_next   = 5'd0;
                        w_frame_err_next = 1'b1;
                    end
                end
            end

            S_OP: begin
                if (w_oe_fall) begin
                    w_state_next     = S_IDLE;
                    w_bit_cnt_next   = 5'd0;
                    w_frame_err_next = 1'b1;
                end else if (w_sample) begin
                    w_sh_next      = w_shin;
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd3) begin
                        if (w_shin[1:0] == 2'b01 || w_shin[1:0] == 2'b10) begin
                            w_is_read_next = w_shin[1];
                            w_state_next   = S_PHYAD;
                        end else begin
                            w_state_next     = S_SKIP;
                            w_frame_err_next = 1'b1;
                        end
                    end
                end
            end

            S_PHYAD: begin
                if (w_oe_fall) begin
                    w_state_next     = S_IDLE;
                    w_bit_cnt_next   = 5'd0;
                    w_frame_err_next = 1'b1;
                end else if (w_sample) begin
                    w_sh_next      = w_shin;
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd8) begin
                        w_state_next = (w_shin[4:0] == PHY_ADDR) ? S_REGAD : S_SKIP;
                    end
                end
            end

            S_REGAD: begin
                if (w_oe_fall) begin
                    w_state_next     = S_IDLE;
                    w_bit_cnt_next   = 5'd0;
                    w_frame_err_next = 1'b1;
                end else if (w_sample) begin
                    w_sh_next      = w_shin;
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd13) begin
                        w_regad_next = w_shin[4:0];
                        w_state_next = S_TA;
                    end
                end
            end

            S_TA: begin
                if (!r_is_read) begin
                    if (w_sample) begin
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd15) begin
                            w_state_next = S_DATA;
                        end
                    end
                end else begin
                    // Master has released the line; count rises blind and start
                    // driving the turnaround zero once the first TA bit has passed.
                    if (w_rise) begin
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                    end
                    if (w_fall && r_bit_cnt == 5'd15) begin
                        w_mdio_in_oe_next = 1'b1;
                        w_mdio_in_next    = 1'b0;
                        w_sh_next         = w_rd_word;
                        w_out_cnt_next    = 5'd0;
                        w_state_next      = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (!r_is_read) begin
                    if (w_oe_fall) begin
                        w_state_next     = S_IDLE;
                        w_bit_cnt_next   = 5'd0;
                        w_frame_err_next = 1'b1;
                    end else if (w_sample) begin
                        w_sh_next = w_shin;
                        if (r_bit_cnt == 5'd31) begin
                            if (!w_ro) begin
                                w_bank_we       = 1'b1;
                                w_wr_pulse_next = 1'b1;
                                w_wr_addr_next  = r_regad;
                                w_wr_data_next  = w_shin;
                            end
                            w_state_next   = S_IDLE;
                            w_bit_cnt_next = 5'd0;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 5'd1;
                        end
                    end
                end else begin
                    if (w_rise && r_bit_cnt != 5'd31) begin
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                    end
                    if (w_fall) begin
                        if (r_out_cnt == 5'd16) begin
                            w_mdio_in_oe_next = 1'b0;
                            w_mdio_in_next    = 1'b0;
                            w_state_next      = S_IDLE;
                            w_bit_cnt_next    = 5'd0;
                        end else begin
                            w_mdio_in_next = r_sh[15];
                            w_sh_next      = {r_sh[14:0], 1'b0};
                            w_out_cnt_next = r_out_cnt + 5'd1;
                        end
                    end
                end
            end

            S_SKIP: begin
                if (w_rise) begin
                    if (r_bit_cnt == 5'd31) begin
                        w_state_next   = S_IDLE;
                        w_bit_cnt_next = 5'd0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                    end
                end
            end

            default: begin
                w_state_next   = S_IDLE;
                w_bit_cnt_next = 5'd0;
            end
        endcase
    end

    assign MDIO_IN    = r_mdio_in;
    assign MDIO_IN_OE = r_mdio_in_oe;
    assign WR_PULSE   = r_wr_pulse;
    assign WR_ADDR    = r_wr_addr;
    assign WR_DATA    = r_wr_data;
    assign FRAME_ERR  = r_frame_err;

endmodule
